pipe_hazard_ctrl: RTL

- Scoreboard-based hazard and issue controller between the ID stage and EX/write-back of the 3-stage 16-bit pipeline.
- Tracks pending register writes and stalls ID when a source register is not yet readable.
- Generates forwarding selects for EX, squashes instructions on flush, and counts stall cycles.

---
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard/issue controller between ID and EX of the 3-stage 16-bit pipeline.
// Tracks pending writes per register, stalls ID on unready sources and drives EX forwarding selects.
module pipe_hazard_ctrl #(
    parameter int NREGS  = 4,
    parameter int WB_LAT = 2,
    parameter int FWD_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [15:0]      id_instr,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic             ex_valid,
    output logic [15:0]      ex_instr,
    output logic             fwd_sel1,
    output logic             fwd_sel2,
    output logic [NREGS-1:0] busy_vec,
    output logic             illegal,
    output logic [15:0]      stall_cycles
);

    localparam logic [2:0] LAT       = 3'(WB_LAT);
    localparam logic [4:0] NREGS_W   = 5'(NREGS);
    localparam logic       FWD_ON    = (FWD_EN != 0);

    logic [3:0]  opcode;
    logic [3:0]  rdIdx;
    logic [3:0]  rs1Idx;
    logic [3:0]  rs2Idx;

    logic        readsRs1;
    logic        readsRs2;
    logic        writesRd;
    logic        legalInstr;

    logic [2:0]  cntRs1;
    logic [2:0]  cntRs2;
    logic        hazRs1;
    logic        hazRs2;
    logic        fwdRs1;
    logic        fwdRs2;

    logic        stallInt;
    logic        issueInt;
    logic        squash;

    logic [2:0]  cnt_q [NREGS];
    logic [2:0]  cnt_d [NREGS];

    logic        exValid_q;
    logic        exValid_d;
    logic [15:0] exInstr_q;
    logic [15:0] exInstr_d;
    logic        fwdSel1_q;
    logic        fwdSel1_d;
    logic        fwdSel2_q;
    logic        fwdSel2_d;
    logic        illegal_q;
    logic        illegal_d;
    logic [15:0] stallCnt_q;
    logic [15:0] stallCnt_d;

    assign opcode = id_instr[15:12];
    assign rdIdx  = id_instr[11:8];
    assign rs1Idx = id_instr[7:4];
    assign rs2Idx = id_instr[3:0];

    // Opcode classes: 0 = NOP, 1..B = rs1+rs2->rd, C..D = rs1->rd, E..F = rs1+rs2 with no write.
    always_comb begin
        readsRs1   = (opcode != 4'h0);
        readsRs2   = (opcode != 4'h0) && (opcode != 4'hC) && (opcode != 4'hD);
        writesRd   = (opcode != 4'h0) && (opcode <= 4'hD);
        legalInstr = (!readsRs1 || ({1'b0, rs1Idx} < NREGS_W)) &&
                     (!readsRs2 || ({1'b0, rs2Idx} < NREGS_W)) &&
                     (!writesRd || ({1'b0, rdIdx}  < NREGS_W));
    end

    // Out-of-range source fields read as idle; such instructions are squashed as illegal anyway.
    always_comb begin
        cntRs1 = 3'd0;
        cntRs2 = 3'd0;
        for (int r = 0; r < NREGS; r++) begin
            if (rs1Idx == 4'(r)) begin
                cntRs1 = cnt_q[r];
            end
            if (rs2Idx == 4'(r)) begin
                cntRs2 = cnt_q[r];
            end
        end
    end

    // A count of one means the producer sits in EX, so forwarding can cover it.
    always_comb begin
        if (FWD_ON) begin
            hazRs1 = (cntRs1 > 3'd1);
            hazRs2 = (cntRs2 > 3'd1);
        end else begin
            hazRs1 = (cntRs1 != 3'd0);
            hazRs2 = (cntRs2 != 3'd0);
        end
        fwdRs1 = FWD_ON && (cntRs1 == 3'd1);
        fwdRs2 = FWD_ON && (cntRs2 == 3'd1);
    end

    always_comb begin
        stallInt = id_valid && !flush && ((readsRs1 && hazRs1) || (readsRs2 && hazRs2));
        issueInt = id_valid && !flush && !stallInt && legalInstr;
        squash   = id_valid && !flush && !stallInt && !legalInstr;
    end

    assign stall = stallInt;
    assign issue = issueInt;

    // Counters drain every cycle; a new write to rd reloads it, so the last writer wins.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != 3'd0) ? (cnt_q[r] - 3'd1) : 3'd0;
            if (issueInt && writesRd && (rdIdx == 4'(r))) begin
                cnt_d[r] = LAT;
            end
        end
    end

    always_comb begin
        exValid_d  = issueInt;
        exInstr_d  = issueInt ? id_instr : 16'h0000;
        fwdSel1_d  = issueInt && readsRs1 && fwdRs1;
        fwdSel2_d  = issueInt && readsRs2 && fwdRs2;
        illegal_d  = squash;
        stallCnt_d = stallCnt_q;
        if (stallInt && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= 3'd0;
            end
            exValid_q  <= 1'b0;
            exInstr_q  <= 16'h0000;
            fwdSel1_q  <= 1'b0;
            fwdSel2_q  <= 1'b0;
            illegal_q  <= 1'b0;
            stallCnt_q <= 16'h0000;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            exValid_q  <= exValid_d;
            exInstr_q  <= exInstr_d;
            fwdSel1_q  <= fwdSel1_d;
            fwdSel2_q  <= fwdSel2_d;
            illegal_q  <= illegal_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_vec[r] = (cnt_q[r] != 3'd0);
        end
    end

    assign ex_valid     = exValid_q;
    assign ex_instr     = exInstr_q;
    assign fwd_sel1     = fwdSel1_q;
    assign fwd_sel2     = fwdSel2_q;
    assign illegal      = illegal_q;
    assign stall_cycles = stallCnt_q;

endmodule
